// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the main-memory access arbiter: block geometry,
// FSM state encoding and the block-base helper.
package mem_access_arbiter_pkg;

   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned ADDR_W          = 16;
   localparam int unsigned DATA_W          = 16;

   // Byte-offset bits inside one block (16-bit words, so 2 bytes per word).
   localparam logic [ADDR_W-1:0] BLOCK_OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

   function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
      return a & ~BLOCK_OFF_MASK;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_fill_word_counter.sv
// Word counter within a cache block; used once for read issue and once for
// data receive. Clear has priority over enable.
module fill_word_counter #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = &r_cnt;

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates main memory between I/D miss fills and D write-through stores,
// sequencing block reads, data-array writes and the final tag write.
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_miss_req,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss_req,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_valid,
   output logic              fill_word_we_i,
   output logic              fill_word_we_d,
   output logic [IDX_W-1:0]  fill_word_idx,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_tag_we_i,
   output logic              fill_tag_we_d,
   output logic              fill_done_i,
   output logic              fill_done_d,
   output logic              d_wr_ack,
   output logic              busy
);

   state_t            r_state;
   logic              r_grant_d;
   logic              r_last_grant_d;
   logic              r_issuing;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;

   logic              w_pick_d;
   logic              w_grant_fill;
   logic              w_issue_en;
   logic [IDX_W-1:0]  w_issue_cnt;
   logic              w_issue_tc;
   logic              w_recv_fire;
   logic [IDX_W-1:0]  w_recv_cnt;
   logic              w_recv_tc;
   logic              w_last;
   logic              w_writing;

   // Round-robin only matters when both misses are pending.
   assign w_pick_d     = d_miss_req && (!i_miss_req || !r_last_grant_d);
   assign w_grant_fill = (r_state == ST_IDLE) && !d_wr_req && (i_miss_req || d_miss_req);
   assign w_issue_en   = (r_state == ST_FILL) && r_issuing;
   assign w_recv_fire  = (r_state == ST_FILL) && mem_data_valid;
   assign w_last       = w_recv_fire && w_recv_tc;
   assign w_writing    = (r_state == ST_WRITE);

   fill_word_counter #(.WIDTH(IDX_W)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_issue_en),
      .i_clr (w_grant_fill),
      .o_cnt (w_issue_cnt),
      .o_tc  (w_issue_tc)
   );

   fill_word_counter #(.WIDTH(IDX_W)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_recv_fire),
      .i_clr (w_grant_fill),
      .o_cnt (w_recv_cnt),
      .o_tc  (w_recv_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_grant_d      <= 1'b0;
         r_last_grant_d <= 1'b0;
         r_issuing      <= 1'b0;
         r_base         <= '0;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (d_wr_req) begin
                  r_wr_addr <= d_wr_addr;
                  r_wr_data <= d_wr_data;
                  r_state   <= ST_WRITE;
               end else if (i_miss_req || d_miss_req) begin
                  r_grant_d      <= w_pick_d;
                  r_last_grant_d <= w_pick_d;
                  r_base         <= block_base(w_pick_d ? d_miss_addr : i_miss_addr);
                  r_issuing      <= 1'b1;
                  r_state        <= ST_FILL;
               end
            end
            ST_WRITE: begin
               r_state <= ST_IDLE;
            end
            ST_FILL: begin
               if (r_issuing && w_issue_tc) begin
                  r_issuing <= 1'b0;
               end
               if (w_last) begin
                  r_issuing <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_en    = r_issuing || w_writing;
   assign mem_wr    = w_writing;
   assign mem_addr  = r_issuing ? (r_base + ADDR_W'({w_issue_cnt, 1'b0}))
                    : (w_writing ? r_wr_addr : '0);
   assign mem_wdata = w_writing ? r_wr_data : '0;
   assign d_wr_ack  = w_writing;
   assign busy      = (r_state != ST_IDLE);

   assign fill_word_we_i = w_recv_fire && !r_grant_d;
   assign fill_word_we_d = w_recv_fire &&  r_grant_d;
   assign fill_word_idx  = w_recv_fire ? w_recv_cnt : '0;
   assign fill_data      = w_recv_fire ? mem_rdata  : '0;
   assign fill_tag_we_i  = w_last && !r_grant_d;
   assign fill_tag_we_d  = w_last &&  r_grant_d;
   assign fill_done_i    = w_last && !r_grant_d;
   assign fill_done_d    = w_last &&  r_grant_d;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a fixed-latency memory model.
module tb_mem_access_arbiter;

   localparam int MEM_LATENCY = 4;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
   } rd_t;

   typedef struct {
      int          cyc;
      logic        d;
      logic [2:0]  idx;
      logic [15:0] data;
      logic        last;
   } fl_t;

   typedef struct {
      int          lo;
      int          hi;
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_miss_req = 1'b0;
   logic [15:0] i_miss_addr = '0;
   logic        d_miss_req = 1'b0;
   logic [15:0] d_miss_addr = '0;
   logic        d_wr_req = 1'b0;
   logic [15:0] d_wr_addr = '0;
   logic [15:0] d_wr_data = '0;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_data_valid = 1'b0;
   logic        fill_word_we_i, fill_word_we_d;
   logic [2:0]  fill_word_idx;
   logic [15:0] fill_data;
   logic        fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d;
   logic        d_wr_ack, busy;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;
   rd_t exp_rd[$];
   fl_t exp_fl[$];
   wr_t exp_wr[$];

   mem_access_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_miss_req     (i_miss_req),
      .i_miss_addr    (i_miss_addr),
      .d_miss_req     (d_miss_req),
      .d_miss_addr    (d_miss_addr),
      .d_wr_req       (d_wr_req),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .fill_word_we_i (fill_word_we_i),
      .fill_word_we_d (fill_word_we_d),
      .fill_word_idx  (fill_word_idx),
      .fill_data      (fill_data),
      .fill_tag_we_i  (fill_tag_we_i),
      .fill_tag_we_d  (fill_tag_we_d),
      .fill_done_i    (fill_done_i),
      .fill_done_d    (fill_done_d),
      .d_wr_ack       (d_wr_ack),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Memory model: a read issued in cycle t returns data in cycle t+MEM_LATENCY.
   logic        dly_v[MEM_LATENCY-1];
   logic [15:0] dly_d[MEM_LATENCY-1];
   initial for (int i = 0; i < MEM_LATENCY - 1; i++) begin
      dly_v[i] = 1'b0;
      dly_d[i] = '0;
   end
   always @(posedge clk) begin
      dly_v[0] <= mem_en && !mem_wr;
      dly_d[0] <= mem_word(mem_addr);
      for (int i = 1; i < MEM_LATENCY - 1; i++) begin
         dly_v[i] <= dly_v[i-1];
         dly_d[i] <= dly_d[i-1];
      end
      mem_data_valid <= dly_v[MEM_LATENCY-2];
      mem_rdata      <= dly_d[MEM_LATENCY-2];
   end

   // Scoreboard: pop and compare whenever the DUT produces a memory access or fill write.
   always @(negedge clk) begin
      rd_t r;
      fl_t f;
      wr_t w;
      logic [5:0] got_fl, exp_f;
      if (mon_en && !rst) begin
         if (mem_en && !mem_wr) begin
            n_tests++;
            if (exp_rd.size() == 0) begin
               n_fail++;
               $display("FAIL rd_unexpected cyc=%0d got addr=%h exp none", cyc, mem_addr);
            end else begin
               r = exp_rd.pop_front();
               if (mem_addr !== r.addr || cyc != r.cyc) begin
                  n_fail++;
                  $display("FAIL rd_issue got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                           mem_addr, cyc, r.addr, r.cyc);
               end
            end
         end
         if (mem_en && mem_wr) begin
            n_tests++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL wr_unexpected cyc=%0d got addr=%h data=%h exp none", cyc, mem_addr, mem_wdata);
            end else begin
               w = exp_wr.pop_front();
               if (mem_addr !== w.addr || mem_wdata !== w.data || d_wr_ack !== 1'b1 ||
                   cyc < w.lo || cyc > w.hi) begin
                  n_fail++;
                  $display("FAIL wr_cycle got addr=%h data=%h ack=%b cyc=%0d exp addr=%h data=%h ack=1 cyc=%0d..%0d",
                           mem_addr, mem_wdata, d_wr_ack, cyc, w.addr, w.data, w.lo, w.hi);
               end
            end
         end
         got_fl = {fill_word_we_i, fill_word_we_d, fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d};
         if (fill_word_we_i || fill_word_we_d) begin
            n_tests++;
            if (exp_fl.size() == 0) begin
               n_fail++;
               $display("FAIL fill_unexpected cyc=%0d got ctl=%b idx=%0d exp none", cyc, got_fl, fill_word_idx);
            end else begin
               f = exp_fl.pop_front();
               exp_f = {!f.d, f.d, !f.d && f.last, f.d && f.last, !f.d && f.last, f.d && f.last};
               if (got_fl !== exp_f || fill_word_idx !== f.idx || fill_data !== f.data || cyc != f.cyc) begin
                  n_fail++;
                  $display("FAIL fill_word got ctl=%b idx=%0d data=%h cyc=%0d exp ctl=%b idx=%0d data=%h cyc=%0d",
                           got_fl, fill_word_idx, fill_data, cyc, exp_f, f.idx, f.data, f.cyc);
               end
            end
         end else begin
            n_tests++;
            if (got_fl !== 6'b0 || (d_wr_ack && !(mem_en && mem_wr))) begin
               n_fail++;
               $display("FAIL stray_pulse cyc=%0d got ctl=%b ack=%b exp ctl=000000 ack=0", cyc, got_fl, d_wr_ack);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

   // Requester behaviour: drop a request once its completion pulse is seen.
   task automatic step();
      @(negedge clk);
      if (fill_done_i) i_miss_req = 1'b0;
      if (fill_done_d) d_miss_req = 1'b0;
      if (d_wr_ack)    d_wr_req   = 1'b0;
   endtask

   task automatic push_fill(input logic d, input logic [15:0] addr, input int t);
      logic [15:0] base, a;
      base = addr & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
         a = base + 16'(2 * k);
         exp_rd.push_back('{cyc: t + 1 + k, addr: a});
         exp_fl.push_back('{cyc: t + 1 + k + MEM_LATENCY, d: d, idx: 3'(k),
                            data: mem_word(a), last: (k == 7)});
      end
   endtask

   task automatic drain(output bit to);
      int n;
      n = 0;
      while ((busy || i_miss_req || d_miss_req || d_wr_req ||
              exp_rd.size() != 0 || exp_fl.size() != 0 || exp_wr.size() != 0) && n < 300) begin
         step();
         n++;
      end
      to = (n >= 300);
   endtask

   task automatic test_reset();
      logic [89:0] outs;
      rst = 1'b1;
      step();
      step();
      outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_word_we_i, fill_word_we_d, fill_word_idx,
              fill_data, fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d, d_wr_ack, busy};
      n_tests++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got %h exp 0", outs);
      end
      rst = 1'b0;
      mon_en = 1'b1;
      step();
      n_tests++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle got busy=%b mem_en=%b exp 0 0", busy, mem_en);
      end
   endtask

   task automatic test_i_fill();
      bit to;
      int t;
      step();
      t = cyc;
      i_miss_addr = 16'h1234;
      i_miss_req  = 1'b1;
      push_fill(1'b0, 16'h1234, t);
      step();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL i_fill_busy got %b exp 1", busy);
      end
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL i_fill_drain got timeout exp complete");
      end
   endtask

   task automatic test_dual_miss();
      bit to;
      int t;
      step();
      t = cyc;
      i_miss_addr = 16'h2468;
      d_miss_addr = 16'h3579;
      i_miss_req  = 1'b1;
      d_miss_req  = 1'b1;
      push_fill(1'b1, 16'h3579, t);
      push_fill(1'b0, 16'h2468, t + 13);
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL dual_drain got timeout exp complete");
      end
   endtask

   task automatic test_write_during_fill();
      bit to;
      int t;
      step();
      t = cyc;
      i_miss_addr = 16'h0500;
      i_miss_req  = 1'b1;
      push_fill(1'b0, 16'h0500, t);
      step();
      step();
      step();
      d_wr_addr = 16'h0040;
      d_wr_data = 16'hBEEF;
      d_wr_req  = 1'b1;
      exp_wr.push_back('{lo: t + 13, hi: t + 14, addr: 16'h0040, data: 16'hBEEF});
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL wr_fill_drain got timeout exp complete");
      end
   endtask

   task automatic test_triple();
      bit to;
      int t;
      step();
      t = cyc;
      d_wr_addr   = 16'h0080;
      d_wr_data   = 16'h1357;
      i_miss_addr = 16'h0B06;
      d_miss_addr = 16'h0A0C;
      d_wr_req    = 1'b1;
      d_miss_req  = 1'b1;
      i_miss_req  = 1'b1;
      exp_wr.push_back('{lo: t + 1, hi: t + 1, addr: 16'h0080, data: 16'h1357});
      push_fill(1'b1, 16'h0A0C, t + 2);
      push_fill(1'b0, 16'h0B06, t + 15);
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL triple_drain got timeout exp complete");
      end
   endtask

   task automatic test_boundary();
      bit to;
      int t;
      step();
      t = cyc;
      d_miss_addr = 16'hFFFA;
      d_miss_req  = 1'b1;
      push_fill(1'b1, 16'hFFFA, t);
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL boundary_drain got timeout exp complete");
      end
   endtask

   task automatic test_round_robin();
      bit to;
      int t;
      step();
      t = cyc;
      i_miss_addr = 16'h4440;
      d_miss_addr = 16'h5552;
      i_miss_req  = 1'b1;
      d_miss_req  = 1'b1;
      push_fill(1'b0, 16'h4440, t);
      push_fill(1'b1, 16'h5552, t + 13);
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL rr_drain got timeout exp complete");
      end
   endtask

   task automatic test_reset_mid_fill();
      bit to;
      int t, bad;
      logic [89:0] outs;
      step();
      t = cyc;
      i_miss_addr = 16'h2000;
      i_miss_req  = 1'b1;
      push_fill(1'b0, 16'h2000, t);
      while (cyc < t + 7) step();
      #2;
      rst        = 1'b1;
      i_miss_req = 1'b0;
      #1;
      outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_word_we_i, fill_word_we_d, fill_word_idx,
              fill_data, fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d, d_wr_ack, busy};
      n_tests++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs got %h exp 0", outs);
      end
      n_tests++;
      if (exp_fl.size() != 5) begin
         n_fail++;
         $display("FAIL mid_reset_words got %0d remaining exp 5", exp_fl.size());
      end
      exp_rd.delete();
      exp_fl.delete();
      step();
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (fill_word_we_i || fill_word_we_d || busy) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL post_reset_ignore got %0d active cycles exp 0", bad);
      end
      t = cyc;
      i_miss_addr = 16'h3456;
      i_miss_req  = 1'b1;
      push_fill(1'b0, 16'h3456, t);
      drain(to);
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL post_reset_fill got timeout exp complete");
      end
   endtask

   initial begin
      test_reset();
      test_i_fill();
      test_dual_miss();
      test_write_during_fill();
      test_triple();
      test_boundary();
      test_round_robin();
      test_reset_mid_fill();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
